// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the registered immediate generator.
//   imm_type_e : code reported alongside every decoded immediate
//   OPC_*      : RV32/RV64 base opcodes recognised by the decoder
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_CSR   = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decoder.
//   inst_code : 32-bit instruction word
//   imm       : immediate, extended to XLEN (0 for illegal / immediate-less encodings)
//   imm_type  : imm_type_e code
//   illegal   : encoding not supported
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_code,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_comb: XLEN must be 32 or 64");
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opcode = inst_code[6:0];
    assign funct3 = inst_code[14:12];

    // Every immediate is formed as a 32-bit value and then sign-extended from bit 31.
    // Zero-extended fields (shamt, zimm) never reach bit 31, so one extension rule
    // covers all cases. Opcode constants all end in 2'b11, so a compressed-space
    // word falls through to the illegal default.
    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm32    = {{20{inst_code[31]}}, inst_code[31:20]};
                imm_type = IMM_I;
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (XLEN == 32 && inst_code[25]) begin
                        illegal = 1'b1;
                    end else begin
                        imm_type = IMM_SHAMT;
                        if (XLEN == 64) imm32 = {26'b0, inst_code[25:20]};
                        else            imm32 = {27'b0, inst_code[24:20]};
                    end
                end else begin
                    imm32    = {{20{inst_code[31]}}, inst_code[31:20]};
                    imm_type = IMM_I;
                end
            end
            OPC_STORE: begin
                imm32    = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
                imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                imm32    = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                            inst_code[30:25], inst_code[11:8], 1'b0};
                imm_type = IMM_B;
            end
            OPC_JAL: begin
                imm32    = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                            inst_code[20], inst_code[30:21], 1'b0};
                imm_type = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32    = {inst_code[31:12], 12'b0};
                imm_type = IMM_U;
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    imm32    = {27'b0, inst_code[19:15]};
                    imm_type = IMM_CSR;
                end
            end
            OPC_OP, OPC_FENCE: begin
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid FIFO and an illegal counter.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input handshake (in_ready depends on occupancy only)
//   inst_code, in_tag     : instruction word and sideband tag
//   out_valid/out_ready   : output handshake
//   imm_out, imm_type     : decoded immediate and its type
//   illegal, out_tag      : illegal flag and returned tag of the head entry
//   illegal_cnt, cnt_clr  : saturating count of accepted illegal words, sync clear
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          inst_code,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm_out,
    output imm_type_e            imm_type,
    output logic                 illegal,
    output logic [TAG_W-1:0]     out_tag,
    output logic [ERR_CNT_W-1:0] illegal_cnt,
    input  logic                 cnt_clr
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_type_e        imm_type;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .inst_code (inst_code),
        .imm       (dec_imm),
        .imm_type  (dec_type),
        .illegal   (dec_illegal)
    );

    entry_t     ent_in;
    entry_t     ent0;       // head, drives the outputs
    entry_t     ent1;
    logic [1:0] count;
    logic       accept;
    logic       pop;

    assign ent_in = '{imm: dec_imm, imm_type: dec_type, illegal: dec_illegal, tag: in_tag};

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b11: begin
                    // accept implies count < 2 and pop implies count > 0, so count is 1
                    ent0 <= ent_in;
                end
                2'b10: begin
                    if (count == 2'd0) ent0 <= ent_in;
                    else               ent1 <= ent_in;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign imm_out  = ent0.imm;
    assign imm_type = ent0.imm_type;
    assign illegal  = ent0.illegal;
    assign out_tag  = ent0.tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (cnt_clr) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cnt_clr;
    logic [31:0] inst_code;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    imm_type_e   type32;
    logic [4:0]  tag32;
    logic [1:0]  cnt32;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    imm_type_e   type64;
    logic [4:0]  tag64;
    logic [15:0] cnt64;

    int total = 0;
    int bad   = 0;
    int exp_cnt32 = 0;
    int exp_cnt64 = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ERR_CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .imm_out(imm32), .imm_type(type32),
        .illegal(illegal32), .out_tag(tag32), .illegal_cnt(cnt32), .cnt_clr(cnt_clr)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ERR_CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .imm_out(imm64), .imm_type(type64),
        .illegal(illegal64), .out_tag(tag64), .illegal_cnt(cnt64), .cnt_clr(cnt_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        imm_type_e   t32;
        logic        ill32;
        logic [63:0] imm64;
        imm_type_e   t64;
        logic        ill64;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_valid32"}, 64'(out_valid32), 64'd0);
        chk({name, "_ready32"}, 64'(in_ready32), 64'd1);
        chk({name, "_valid64"}, 64'(out_valid64), 64'd0);
        chk({name, "_ready64"}, 64'(in_ready64), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, IMM_I,     1'b0, 64'hFFFFFFFFFFFFFFFF, IMM_I,     1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, IMM_B,     1'b0, 64'hFFFFFFFFFFFFFFFC, IMM_B,     1'b0};
        vecs[2]  = '{32'h123452B7, 32'h12345000, IMM_U,     1'b0, 64'h0000000012345000, IMM_U,     1'b0};
        vecs[3]  = '{32'h800002B7, 32'h80000000, IMM_U,     1'b0, 64'hFFFFFFFF80000000, IMM_U,     1'b0};
        vecs[4]  = '{32'h02009093, 32'h00000000, IMM_NONE,  1'b1, 64'h0000000000000020, IMM_SHAMT, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h00000000, IMM_NONE,  1'b1, 64'h0000000000000000, IMM_NONE,  1'b1};
        vecs[6]  = '{32'hFE20AC23, 32'hFFFFFFF8, IMM_S,     1'b0, 64'hFFFFFFFFFFFFFFF8, IMM_S,     1'b0};
        vecs[7]  = '{32'h001000EF, 32'h00000800, IMM_J,     1'b0, 64'h0000000000000800, IMM_J,     1'b0};
        vecs[8]  = '{32'hFFFFD073, 32'h0000001F, IMM_CSR,   1'b0, 64'h000000000000001F, IMM_CSR,   1'b0};
        vecs[9]  = '{32'h00000073, 32'h00000000, IMM_NONE,  1'b0, 64'h0000000000000000, IMM_NONE,  1'b0};
        vecs[10] = '{32'h002081B3, 32'h00000000, IMM_NONE,  1'b0, 64'h0000000000000000, IMM_NONE,  1'b0};
        vecs[11] = '{32'h0FF0000F, 32'h00000000, IMM_NONE,  1'b0, 64'h0000000000000000, IMM_NONE,  1'b0};
        vecs[12] = '{32'hFFFFF017, 32'hFFFFF000, IMM_U,     1'b0, 64'hFFFFFFFFFFFFF000, IMM_U,     1'b0};
        vecs[13] = '{32'h40315093, 32'h00000003, IMM_SHAMT, 1'b0, 64'h0000000000000003, IMM_SHAMT, 1'b0};
        vecs[14] = '{32'h7FF08067, 32'h000007FF, IMM_I,     1'b0, 64'h00000000000007FF, IMM_I,     1'b0};
        vecs[15] = '{32'hFFF00090, 32'h00000000, IMM_NONE,  1'b1, 64'h0000000000000000, IMM_NONE,  1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        inst_code = 32'h0;
        in_tag    = 5'd0;
        #12;
        chk_empty("reset");
        chk("reset_imm32",  64'(imm32),  64'd0);
        chk("reset_type32", 64'(type32), 64'(IMM_NONE));
        chk("reset_ill32",  64'(illegal32), 64'd0);
        chk("reset_tag32",  64'(tag32),  64'd0);
        chk("reset_cnt32",  64'(cnt32),  64'd0);
        chk("reset_imm64",  64'(imm64),  64'd0);
        chk("reset_cnt64",  64'(cnt64),  64'd0);
        rst_n = 1'b1;
        tick();

        // Streaming table: one word per cycle with out_ready high, so each entry
        // is observed the cycle after it is pushed and popped on the following edge.
        for (int i = 0; i < NVEC; i++) begin
            in_valid  = 1'b1;
            inst_code = vecs[i].inst;
            in_tag    = 5'(i + 1);
            tick();
            if (vecs[i].ill32 && exp_cnt32 < 3) exp_cnt32++;
            if (vecs[i].ill64) exp_cnt64++;
            chk($sformatf("v%0d_valid32", i), 64'(out_valid32), 64'd1);
            chk($sformatf("v%0d_imm32", i),   64'(imm32),       64'(vecs[i].imm32));
            chk($sformatf("v%0d_type32", i),  64'(type32),      64'(vecs[i].t32));
            chk($sformatf("v%0d_ill32", i),   64'(illegal32),   64'(vecs[i].ill32));
            chk($sformatf("v%0d_tag32", i),   64'(tag32),       64'(i + 1));
            chk($sformatf("v%0d_cnt32", i),   64'(cnt32),       64'(exp_cnt32));
            chk($sformatf("v%0d_valid64", i), 64'(out_valid64), 64'd1);
            chk($sformatf("v%0d_imm64", i),   imm64,            vecs[i].imm64);
            chk($sformatf("v%0d_type64", i),  64'(type64),      64'(vecs[i].t64));
            chk($sformatf("v%0d_ill64", i),   64'(illegal64),   64'(vecs[i].ill64));
            chk($sformatf("v%0d_tag64", i),   64'(tag64),       64'(i + 1));
            chk($sformatf("v%0d_cnt64", i),   64'(cnt64),       64'(exp_cnt64));
        end
        in_valid = 1'b0;
        tick();
        chk_empty("drain");

        // Back-pressure: three words offered while the consumer stalls.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst_code = 32'hFFF00093;
        in_tag    = 5'd1;
        tick();
        chk("bp_ready_after1", 64'(in_ready32), 64'd1);
        in_tag = 5'd2;
        tick();
        chk("bp_ready_full", 64'(in_ready32), 64'd0);
        chk("bp_head_tag1",  64'(tag32), 64'd1);
        in_tag = 5'd3;
        tick();
        chk("bp_ready_stall", 64'(in_ready32), 64'd0);
        chk("bp_head_stable", 64'(tag32), 64'd1);
        chk("bp_imm_stable",  64'(imm32), 64'hFFFFFFFF);
        out_ready = 1'b1;
        tick();
        chk("bp_pop_tag2",  64'(tag32), 64'd2);
        chk("bp_pop_valid", 64'(out_valid32), 64'd1);
        chk("bp_ready_back", 64'(in_ready32), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_pop_tag3",  64'(tag32), 64'd3);
        chk("bp_tag3_valid", 64'(out_valid32), 64'd1);
        tick();
        chk_empty("bp_end");

        // Concurrent push and pop with one entry held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd10;
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_tag = 5'(11 + k);
            tick();
            chk($sformatf("pp%0d_ready", k), 64'(in_ready32),  64'd1);
            chk($sformatf("pp%0d_valid", k), 64'(out_valid32), 64'd1);
            chk($sformatf("pp%0d_tag", k),   64'(tag32),       64'(11 + k));
        end
        in_valid = 1'b0;
        tick();
        chk_empty("pp_end");

        // Counter saturation on the 2-bit instance.
        cnt_clr = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        exp_cnt32 = 0;
        exp_cnt64 = 0;
        chk("clr_cnt32", 64'(cnt32), 64'd0);
        chk("clr_cnt64", 64'(cnt64), 64'd0);
        in_valid  = 1'b1;
        inst_code = 32'h00000000;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (exp_cnt32 < 3) exp_cnt32++;
            exp_cnt64++;
            chk($sformatf("sat%0d_cnt32", k), 64'(cnt32), 64'(exp_cnt32));
            chk($sformatf("sat%0d_cnt64", k), 64'(cnt64), 64'(exp_cnt64));
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        chk("clr_win_cnt32", 64'(cnt32), 64'd0);
        chk("clr_win_cnt64", 64'(cnt64), 64'd0);
        tick();

        // Asynchronous reset with both entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst_code = 32'hFFF00093;
        in_tag    = 5'd7;
        tick();
        in_tag = 5'd8;
        tick();
        in_valid = 1'b0;
        chk("rst_pre_full",  64'(in_ready32),  64'd0);
        chk("rst_pre_valid", 64'(out_valid32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_empty("rst_mid");
        chk("rst_mid_tag",   64'(tag32), 64'd0);
        chk("rst_mid_imm64", imm64,      64'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_empty("rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
